// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a small byte FIFO and active-low CTS flow control.
`timescale 1ns/1ps
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          sample_clock,
  input  logic                          key,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          uart_cts,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic              pop;
  logic              push;
  logic              baud_last;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              cts_meta_q, cts_sync_q;
  logic              cts_ok;

  assign tx_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign push       = tx_valid & tx_ready;
  assign fifo_count = count_q;
  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign cts_ok     = ~cts_sync_q;
  assign baud_last  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Two-flop CTS synchronizer; resets to "not clear to send".
  always_ff @(posedge sample_clock or negedge key) begin
    if (!key) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= uart_cts;
      cts_sync_q <= cts_meta_q;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge sample_clock) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel.
  always_ff @(posedge sample_clock or negedge key) begin
    if (!key) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Framer state register, including the registered line and status outputs.
  always_ff @(posedge sample_clock or negedge key) begin
    if (!key) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state logic; tx_d is the line level for the state/bit being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if ((count_q != '0) && cts_ok) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
